resgen_chroma8x8: RTL

RESGEN_CHROMA8X8 -- requirements
Module: resgen_chroma8x8

---
 rtl/resgen_chroma8x8.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/resgen_chroma8x8.sv
// 8x8 chroma residual generator: loads neighbours and an original block, then forms
// vertical, horizontal and DC prediction residuals and pulses the SAD stage enable.
module resgen_chroma8x8 #(
   parameter int unsigned DC_DEFAULT = 128
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       top_avail,
   input  logic       left_avail,
   input  logic       in_valid,
   input  logic [7:0] top_in,
   input  logic [7:0] left_in,
   input  logic [7:0] orig_in,
   output logic       busy,
   output logic [7:0] vres  [64],
   output logic [7:0] hres  [64],
   output logic [7:0] dcres [64],
   output logic       sad_enable
);

   typedef enum logic [2:0] {
      IDLE,
      LOAD_NBR,
      LOAD_ORIG,
      COMPUTE,
      EMIT
   } state_t;

   localparam logic [7:0] DcDefault = 8'(DC_DEFAULT);

   state_t     state_q, state_d;
   logic [5:0] beatCnt_q, beatCnt_d;
   logic       topAvail_q, topAvail_d;
   logic       leftAvail_q, leftAvail_d;

   logic [7:0] top_q  [8];
   logic [7:0] left_q [8];
   logic [7:0] orig_q [64];

   logic [10:0] sumTop, sumLeft;
   logic [11:0] sumBoth;
   logic [7:0]  dcPred;
   logic [7:0]  vres_d  [64];
   logic [7:0]  hres_d  [64];
   logic [7:0]  dcres_d [64];

   function automatic logic [7:0] satDiff(input logic [7:0] a, input logic [7:0] b);
      logic [8:0] d;
      d = {1'b0, a} - {1'b0, b};
      if (d[8] == d[7]) return d[7:0];
      else              return d[8] ? 8'h80 : 8'h7F;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         beatCnt_q   <= '0;
         topAvail_q  <= 1'b0;
         leftAvail_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         beatCnt_q   <= beatCnt_d;
         topAvail_q  <= topAvail_d;
         leftAvail_q <= leftAvail_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      beatCnt_d   = beatCnt_q;
      topAvail_d  = topAvail_q;
      leftAvail_d = leftAvail_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               topAvail_d  = top_avail;
               leftAvail_d = left_avail;
               beatCnt_d   = '0;
               state_d     = LOAD_NBR;
            end
         end
         LOAD_NBR: begin
            if (in_valid) begin
               if (beatCnt_q == 6'd7) begin
                  beatCnt_d = '0;
                  state_d   = LOAD_ORIG;
               end else begin
                  beatCnt_d = beatCnt_q + 6'd1;
               end
            end
         end
         LOAD_ORIG: begin
            if (in_valid) begin
               if (beatCnt_q == 6'd63) begin
                  beatCnt_d = '0;
                  state_d   = COMPUTE;
               end else begin
                  beatCnt_d = beatCnt_q + 6'd1;
               end
            end
         end
         COMPUTE: state_d = EMIT;
         EMIT:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Sample storage is never reset; every entry is rewritten before COMPUTE reads it.
   always_ff @(posedge clk) begin
      if (state_q == LOAD_NBR && in_valid) begin
         top_q[beatCnt_q[2:0]]  <= top_in;
         left_q[beatCnt_q[2:0]] <= left_in;
      end
      if (state_q == LOAD_ORIG && in_valid) begin
         orig_q[beatCnt_q] <= orig_in;
      end
   end

   // The combined sum needs a 12th bit: 16 samples of 255 plus rounding reach 4088.
   always_comb begin
      sumTop  = '0;
      sumLeft = '0;
      for (int k = 0; k < 8; k++) begin
         sumTop  = sumTop  + {3'b000, top_q[k]};
         sumLeft = sumLeft + {3'b000, left_q[k]};
      end
      sumBoth = {1'b0, sumTop} + {1'b0, sumLeft} + 12'd8;
      unique case ({topAvail_q, leftAvail_q})
         2'b11:   dcPred = 8'(sumBoth >> 4);
         2'b10:   dcPred = 8'((sumTop + 11'd4) >> 3);
         2'b01:   dcPred = 8'((sumLeft + 11'd4) >> 3);
         default: dcPred = DcDefault;
      endcase
   end

   always_comb begin
      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < 8; c++) begin
            vres_d[r*8+c]  = satDiff(orig_q[r*8+c], topAvail_q  ? top_q[c]  : DcDefault);
            hres_d[r*8+c]  = satDiff(orig_q[r*8+c], leftAvail_q ? left_q[r] : DcDefault);
            dcres_d[r*8+c] = satDiff(orig_q[r*8+c], dcPred);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 64; i++) begin
            vres[i]  <= '0;
            hres[i]  <= '0;
            dcres[i] <= '0;
         end
      end else if (state_q == COMPUTE) begin
         for (int i = 0; i < 64; i++) begin
            vres[i]  <= vres_d[i];
            hres[i]  <= hres_d[i];
            dcres[i] <= dcres_d[i];
         end
      end
   end

   assign busy       = (state_q != IDLE);
   assign sad_enable = (state_q == EMIT);

endmodule
